// File: rtl/jtag_tap_pkg.sv
// TAP controller state codes and fixed instruction opcodes shared by the TAP generator.
// Pure definitions; no latency or flow control.
package jtag_tap_pkg;

  localparam logic [3:0] ST_EXIT2_DR   = 4'h0;
  localparam logic [3:0] ST_EXIT1_DR   = 4'h1;
  localparam logic [3:0] ST_SHIFT_DR   = 4'h2;
  localparam logic [3:0] ST_PAUSE_DR   = 4'h3;
  localparam logic [3:0] ST_SELECT_IR  = 4'h4;
  localparam logic [3:0] ST_UPDATE_DR  = 4'h5;
  localparam logic [3:0] ST_CAPTURE_DR = 4'h6;
  localparam logic [3:0] ST_SELECT_DR  = 4'h7;
  localparam logic [3:0] ST_EXIT2_IR   = 4'h8;
  localparam logic [3:0] ST_EXIT1_IR   = 4'h9;
  localparam logic [3:0] ST_SHIFT_IR   = 4'hA;
  localparam logic [3:0] ST_PAUSE_IR   = 4'hB;
  localparam logic [3:0] ST_RUN_IDLE   = 4'hC;
  localparam logic [3:0] ST_UPDATE_IR  = 4'hD;
  localparam logic [3:0] ST_CAPTURE_IR = 4'hE;
  localparam logic [3:0] ST_TLR        = 4'hF;

  typedef enum logic [3:0] {
    S_EXIT2_DR   = ST_EXIT2_DR,
    S_EXIT1_DR   = ST_EXIT1_DR,
    S_SHIFT_DR   = ST_SHIFT_DR,
    S_PAUSE_DR   = ST_PAUSE_DR,
    S_SELECT_IR  = ST_SELECT_IR,
    S_UPDATE_DR  = ST_UPDATE_DR,
    S_CAPTURE_DR = ST_CAPTURE_DR,
    S_SELECT_DR  = ST_SELECT_DR,
    S_EXIT2_IR   = ST_EXIT2_IR,
    S_EXIT1_IR   = ST_EXIT1_IR,
    S_SHIFT_IR   = ST_SHIFT_IR,
    S_PAUSE_IR   = ST_PAUSE_IR,
    S_RUN_IDLE   = ST_RUN_IDLE,
    S_UPDATE_IR  = ST_UPDATE_IR,
    S_CAPTURE_IR = ST_CAPTURE_IR,
    S_TLR        = ST_TLR
  } tap_state_t;

  // Opcodes are stored wide and truncated to the instance IR width (BYPASS stays all-ones).
  localparam logic [15:0] OPC_IDCODE = 16'h0002;
  localparam logic [15:0] OPC_BYPASS = 16'hFFFF;

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP state machine: state register plus next-state logic, advances on rising tck.
// One state per tck edge; no backpressure.
module jtag_tap_fsm
  import jtag_tap_pkg::*;
(
  input  logic       tck,
  input  logic       rst,
  input  logic       tms,
  output tap_state_t state
);

  tap_state_t state_q;
  tap_state_t state_d;

  always_ff @(posedge tck or posedge rst) begin
    if (rst) state_q <= S_TLR;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_TLR:        state_d = tms ? S_TLR        : S_RUN_IDLE;
      S_RUN_IDLE:   state_d = tms ? S_SELECT_DR  : S_RUN_IDLE;
      S_SELECT_DR:  state_d = tms ? S_SELECT_IR  : S_CAPTURE_DR;
      S_CAPTURE_DR: state_d = tms ? S_EXIT1_DR   : S_SHIFT_DR;
      S_SHIFT_DR:   state_d = tms ? S_EXIT1_DR   : S_SHIFT_DR;
      S_EXIT1_DR:   state_d = tms ? S_UPDATE_DR  : S_PAUSE_DR;
      S_PAUSE_DR:   state_d = tms ? S_EXIT2_DR   : S_PAUSE_DR;
      S_EXIT2_DR:   state_d = tms ? S_UPDATE_DR  : S_SHIFT_DR;
      S_UPDATE_DR:  state_d = tms ? S_SELECT_DR  : S_RUN_IDLE;
      S_SELECT_IR:  state_d = tms ? S_TLR        : S_CAPTURE_IR;
      S_CAPTURE_IR: state_d = tms ? S_EXIT1_IR   : S_SHIFT_IR;
      S_SHIFT_IR:   state_d = tms ? S_EXIT1_IR   : S_SHIFT_IR;
      S_EXIT1_IR:   state_d = tms ? S_UPDATE_IR  : S_PAUSE_IR;
      S_PAUSE_IR:   state_d = tms ? S_EXIT2_IR   : S_PAUSE_IR;
      S_EXIT2_IR:   state_d = tms ? S_UPDATE_IR  : S_SHIFT_IR;
      S_UPDATE_IR:  state_d = tms ? S_SELECT_DR  : S_RUN_IDLE;
      default:      state_d = S_TLR;
    endcase
  end

  assign state = state_q;

endmodule

// File: rtl/jtag_tap_gen.sv
// JTAG TAP with IDCODE/BYPASS and NUM_CH lockable user DR channels; td_o registered on falling tck.
// Serial protocol, one bit per tck; no backpressure.
module jtag_tap_gen
  import jtag_tap_pkg::*;
#(
  parameter int                   IR_WIDTH   = 5,
  parameter int                   NUM_CH     = 6,
  parameter logic [IR_WIDTH-1:0]  USER_BASE  = IR_WIDTH'(4),
  parameter logic [31:0]          IDCODE_VAL = 32'h1000_0045
) (
  input  logic                tck_i,
  input  logic                rst_i,
  input  logic                tms_i,
  input  logic                td_i,
  input  logic                lock_i,
  input  logic [NUM_CH-1:0]   ch_tdo_i,
  output logic                td_o,
  output logic                td_oe_o,
  output logic                scan_in_o,
  output logic [NUM_CH-1:0]   ch_sel_o,
  output logic                capture_dr_o,
  output logic                shift_dr_o,
  output logic                update_dr_o,
  output logic [IR_WIDTH-1:0] ir_o,
  output logic [3:0]          state_o
);

  localparam logic [IR_WIDTH-1:0] IR_IDCODE  = OPC_IDCODE[IR_WIDTH-1:0];
  localparam logic [IR_WIDTH-1:0] IR_BYPASS  = OPC_BYPASS[IR_WIDTH-1:0];
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);
  localparam logic [31:0]         NUM_CH_U   = 32'(NUM_CH);

  tap_state_t          state;
  logic [IR_WIDTH-1:0] ir_sr;
  logic [IR_WIDTH-1:0] ir_q;
  logic                lock_q;
  logic [31:0]         idc_sr;
  logic                byp_sr;
  logic [IR_WIDTH-1:0] ch_off;
  logic [3:0]          ch_idx;
  logic                sel_idcode;
  logic                ch_hit;
  logic [NUM_CH-1:0]   ch_sel;
  logic                td_q;
  logic                oe_q;

  jtag_tap_fsm u_fsm (
    .tck   (tck_i),
    .rst   (rst_i),
    .tms   (tms_i),
    .state (state)
  );

  // A locked user opcode falls through to BYPASS; IDCODE and all-ones never reach the channel range.
  assign ch_off = ir_q - USER_BASE;
  assign ch_idx = 4'(ch_off);

  always_comb begin
    sel_idcode = (ir_q == IR_IDCODE);
    ch_hit     = !sel_idcode && (ir_q != IR_BYPASS) && (ir_q >= USER_BASE) &&
                 (32'(ch_off) < NUM_CH_U) && !lock_q;
    ch_sel     = ch_hit ? (NUM_CH'(1) << ch_idx) : '0;
  end

  always_ff @(posedge tck_i or posedge rst_i) begin
    if (rst_i) begin
      ir_sr  <= '0;
      ir_q   <= IR_IDCODE;
      lock_q <= 1'b0;
      idc_sr <= '0;
      byp_sr <= 1'b0;
    end else begin
      case (state)
        S_TLR: begin
          ir_sr  <= '0;
          ir_q   <= IR_IDCODE;
          lock_q <= 1'b0;
          idc_sr <= '0;
          byp_sr <= 1'b0;
        end
        S_CAPTURE_IR: ir_sr <= IR_CAPTURE;
        S_SHIFT_IR:   ir_sr <= {td_i, ir_sr[IR_WIDTH-1:1]};
        S_UPDATE_IR: begin
          ir_q   <= ir_sr;
          lock_q <= lock_i;
        end
        S_CAPTURE_DR: begin
          idc_sr <= IDCODE_VAL;
          byp_sr <= 1'b0;
        end
        S_SHIFT_DR: begin
          idc_sr <= {td_i, idc_sr[31:1]};
          byp_sr <= td_i;
        end
        default: ;
      endcase
    end
  end

  // Falling-edge output stage gives the probe a full half cycle of setup on td_o.
  always_ff @(negedge tck_i or posedge rst_i) begin
    if (rst_i) begin
      td_q <= 1'b0;
      oe_q <= 1'b0;
    end else if (state == S_SHIFT_IR) begin
      td_q <= ir_sr[0];
      oe_q <= 1'b1;
    end else if (state == S_SHIFT_DR) begin
      td_q <= ch_hit ? |(ch_tdo_i & ch_sel) : (sel_idcode ? idc_sr[0] : byp_sr);
      oe_q <= 1'b1;
    end else begin
      td_q <= 1'b0;
      oe_q <= 1'b0;
    end
  end

  assign td_o         = td_q;
  assign td_oe_o      = oe_q;
  assign scan_in_o    = td_i;
  assign ch_sel_o     = ch_sel;
  assign capture_dr_o = ch_hit && (state == S_CAPTURE_DR);
  assign shift_dr_o   = ch_hit && (state == S_SHIFT_DR);
  assign update_dr_o  = ch_hit && (state == S_UPDATE_DR);
  assign ir_o         = ir_q;
  assign state_o      = state;

endmodule

// File: tb/tb_jtag_tap_gen.sv
// Directed bench for jtag_tap_gen: stimulus queues expected td_o bits, a falling-edge monitor checks them.
module tb_jtag_tap_gen;

  localparam int NCH = 6;

  logic           tck = 1'b0;
  logic           rst = 1'b0;
  logic           tms = 1'b1;
  logic           tdi = 1'b0;
  logic           lock = 1'b0;
  logic [NCH-1:0] ch_tdo = '0;
  logic           tdo, tdo_oe, scan_in, cap, sh, upd;
  logic [NCH-1:0] ch_sel;
  logic [4:0]     ir;
  logic [3:0]     st;

  int checks = 0;
  int errors = 0;
  bit exp_q[$];
  int oe_cnt = 0, sh_cnt = 0, cap_cnt = 0, upd_cnt = 0;
  logic [31:0] idc_exp = 32'h1000_0045;

  jtag_tap_gen #(
    .IR_WIDTH   (5),
    .NUM_CH     (NCH),
    .USER_BASE  (5'b00100),
    .IDCODE_VAL (32'h1000_0045)
  ) dut (
    .tck_i        (tck),
    .rst_i        (rst),
    .tms_i        (tms),
    .td_i         (tdi),
    .lock_i       (lock),
    .ch_tdo_i     (ch_tdo),
    .td_o         (tdo),
    .td_oe_o      (tdo_oe),
    .scan_in_o    (scan_in),
    .ch_sel_o     (ch_sel),
    .capture_dr_o (cap),
    .shift_dr_o   (sh),
    .update_dr_o  (upd),
    .ir_o         (ir),
    .state_o      (st)
  );

  always #5 tck = ~tck;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic t, input logic d);
    tms = t;
    tdi = d;
    @(posedge tck);
    #1;
  endtask

  task automatic clr_cnt();
    oe_cnt = 0; sh_cnt = 0; cap_cnt = 0; upd_cnt = 0;
  endtask

  // Run-Test/Idle -> Shift-DR, n bits LSB-first, -> Update-DR -> Run-Test/Idle
  task automatic shift_dr(input int n, input logic [31:0] din);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < n; i++) step(i == n - 1, din[i]);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  // Captured IR pattern 0..01 always comes out first, LSB-first.
  task automatic shift_ir(input logic [4:0] v);
    exp_q.push_back(1'b1);
    repeat (4) exp_q.push_back(1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(i == 4, v[i]);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  initial forever begin
    @(negedge tck);
    #1;
    if (tdo_oe) begin
      oe_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL td_o unexpected shift bit: got %0b expected none", tdo);
      end else begin
        chk("td_o shift bit", {31'b0, tdo}, {31'b0, exp_q.pop_front()});
      end
    end else begin
      chk("td_o idle low", {31'b0, tdo}, 32'h0);
    end
    chk("scan_in", {31'b0, scan_in}, {31'b0, tdi});
    sh_cnt  += int'(sh);
    cap_cnt += int'(cap);
    upd_cnt += int'(upd);
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    #2 rst = 1'b1;
    #2;
    chk("reset state", {28'b0, st}, 32'hF);
    chk("reset ir", {27'b0, ir}, 32'h2);
    chk("reset td_o", {31'b0, tdo}, 32'h0);
    chk("reset td_oe", {31'b0, tdo_oe}, 32'h0);
    chk("reset ch_sel", {26'b0, ch_sel}, 32'h0);
    repeat (2) @(posedge tck);
    #1 rst = 1'b0;
    step(1'b0, 1'b0);
    chk("idle state", {28'b0, st}, 32'hC);

    // IDCODE read straight after reset
    for (int i = 0; i < 32; i++) exp_q.push_back(idc_exp[i]);
    clr_cnt();
    shift_dr(32, 32'h0);
    chk("idcode oe count", oe_cnt, 32);
    chk("idcode shift strobes", sh_cnt, 0);
    chk("idcode capture strobes", cap_cnt, 0);

    // BYPASS load then TMS-driven reset back to IDCODE
    shift_ir(5'h1F);
    chk("bypass ir", {27'b0, ir}, 32'h1F);
    repeat (5) step(1'b1, 1'b0);
    chk("tms reset state", {28'b0, st}, 32'hF);
    chk("tms reset ir", {27'b0, ir}, 32'h2);
    step(1'b0, 1'b0);

    // channel 2 unlocked
    ch_tdo = 6'b000100;
    shift_ir(5'h06);
    chk("ch2 ir", {27'b0, ir}, 32'h6);
    chk("ch2 ch_sel", {26'b0, ch_sel}, 32'h4);
    repeat (8) exp_q.push_back(1'b1);
    clr_cnt();
    shift_dr(8, 32'h5A);
    chk("ch2 oe count", oe_cnt, 8);
    chk("ch2 shift strobes", sh_cnt, 8);
    chk("ch2 capture strobes", cap_cnt, 1);
    chk("ch2 update strobes", upd_cnt, 1);

    // channel 2 locked: falls back to BYPASS even after lock_i drops
    lock = 1'b1;
    shift_ir(5'h06);
    lock = 1'b0;
    chk("locked ir", {27'b0, ir}, 32'h6);
    chk("locked ch_sel", {26'b0, ch_sel}, 32'h0);
    exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    clr_cnt();
    shift_dr(4, 32'b0101);
    chk("locked oe count", oe_cnt, 4);
    chk("locked shift strobes", sh_cnt, 0);
    chk("locked capture strobes", cap_cnt, 0);
    chk("locked update strobes", upd_cnt, 0);

    // unmapped opcode decodes as BYPASS
    shift_ir(5'b11000);
    chk("unmapped ir", {27'b0, ir}, 32'h18);
    chk("unmapped ch_sel", {26'b0, ch_sel}, 32'h0);
    exp_q.push_back(1'b0); exp_q.push_back(1'b1); exp_q.push_back(1'b1);
    clr_cnt();
    shift_dr(3, 32'b011);
    chk("unmapped oe count", oe_cnt, 3);

    // channel 0, reset asserted part-way through Shift-DR
    ch_tdo = 6'b000001;
    shift_ir(5'h04);
    chk("ch0 ch_sel", {26'b0, ch_sel}, 32'h1);
    clr_cnt();
    exp_q.push_back(1'b1); exp_q.push_back(1'b1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("mid shift state", {28'b0, st}, 32'h2);
    rst = 1'b1;
    #1;
    chk("async rst state", {28'b0, st}, 32'hF);
    chk("async rst ir", {27'b0, ir}, 32'h2);
    chk("async rst ch_sel", {26'b0, ch_sel}, 32'h0);
    chk("async rst td_o", {31'b0, tdo}, 32'h0);
    chk("async rst td_oe", {31'b0, tdo_oe}, 32'h0);
    chk("async rst shift_dr", {31'b0, sh}, 32'h0);
    chk("async rst update_dr", {31'b0, upd}, 32'h0);
    repeat (3) @(posedge tck);
    #1 rst = 1'b0;
    step(1'b0, 1'b0);
    chk("post rst state", {28'b0, st}, 32'hC);
    chk("ch0 capture strobes", cap_cnt, 1);
    chk("ch0 oe count", oe_cnt, 2);
    chk("ch0 update strobes", upd_cnt, 0);

    chk("expected queue drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
